// File: rtl/conv_pkg.sv
// Shared convolver constants and the window generator state type.
package conv_pkg;
  localparam int KERNEL_SIZE = 5;
  localparam int NUM_TAPS = KERNEL_SIZE * KERNEL_SIZE;

  typedef enum logic {
    FILL,
    STREAM
  } state_t;
endpackage

// File: rtl/line_buffer.sv
// Fixed-length delay line that advances only when a pixel is accepted.
module line_buffer #(
  parameter int DEPTH = 23,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] delayed
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign delayed = data;
    end else begin : g_line
      logic [DATA_WIDTH-1:0] mem [DEPTH];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
          end
        end else if (en) begin
          mem[0] <= data;
          for (int i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
          end
        end
      end

      assign delayed = mem[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/conv_window_buffer.sv
// Streaming 5x5 sliding-window generator: four line buffers feed a
// 5x5 register window; taps are presented in adder-tree order.
module conv_window_buffer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [DATA_WIDTH-1:0]   pixel_in,
  input  logic                           pixel_valid,
  input  logic                           clear,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] window_out,
  output logic                           window_valid,
  output logic                           frame_done
);

  localparam int K = KERNEL_SIZE;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic signed [DATA_WIDTH-1:0] win [K][K];
  logic signed [DATA_WIDTH-1:0] nxt [K][K];
  logic [DATA_WIDTH-1:0] lb_out [K-1];
  logic [NUM_TAPS*DATA_WIDTH-1:0] next_flat;

  logic [CW-1:0] col, col_n, c0;
  logic [RW-1:0] row, row_n, r0;
  state_t state, state_n;
  logic emit, last;

  // Line buffer i carries pixels leaving window row i+1 up to row i.
  generate
    for (genvar g = 0; g < K - 1; g++) begin : g_lb
      line_buffer #(
        .DEPTH(IMG_WIDTH - K),
        .DATA_WIDTH(DATA_WIDTH)
      ) u_lb (
        .clk(clk),
        .reset(reset),
        .en(pixel_valid),
        .data(win[g+1][0]),
        .delayed(lb_out[g])
      );
    end
  endgenerate

  always_comb begin
    next_flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        if (j < K - 1) begin
          nxt[i][j] = win[i][j+1];
        end else if (i == K - 1) begin
          nxt[i][j] = pixel_in;
        end else begin
          nxt[i][j] = lb_out[i];
        end
        next_flat[(i*K+j)*DATA_WIDTH +: DATA_WIDTH] = nxt[i][j];
      end
    end
  end

  always_comb begin
    r0 = clear ? '0 : row;
    c0 = clear ? '0 : col;
    row_n = r0;
    col_n = c0;
    state_n = clear ? FILL : state;
    if (pixel_valid) begin
      if (c0 == CW'(IMG_WIDTH - 1)) begin
        col_n = '0;
        if (r0 == RW'(IMG_HEIGHT - 1)) begin
          row_n = '0;
          state_n = FILL;
        end else begin
          row_n = r0 + RW'(1);
          if (r0 == RW'(K - 2)) begin
            state_n = STREAM;
          end
        end
      end else begin
        col_n = c0 + CW'(1);
      end
    end
  end

  assign emit = pixel_valid && !clear && (state == STREAM) &&
                (col >= CW'(K - 1));
  assign last = (row == RW'(IMG_HEIGHT - 1)) &&
                (col == CW'(IMG_WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
      row <= '0;
      col <= '0;
    end else begin
      state <= state_n;
      row <= row_n;
      col <= col_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          win[i][j] <= '0;
        end
      end
    end else if (pixel_valid) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          win[i][j] <= nxt[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window_out <= '0;
      window_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      window_valid <= emit;
      frame_done <= emit && last;
      if (emit) begin
        window_out <= next_flat;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer on an 8x8 image where
// pixel value = row*8+col.
module tb_conv_window_buffer;
  localparam int DW = 16;
  localparam int W = 8;
  localparam int H = 8;
  localparam int OW = 25 * DW;

  logic clk;
  logic reset;
  logic signed [DW-1:0] pixel_in;
  logic pixel_valid;
  logic clear;
  logic [OW-1:0] window_out;
  logic window_valid;
  logic frame_done;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [OW-1:0] last_w;

  conv_window_buffer #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH(W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pixel_in(pixel_in),
    .pixel_valid(pixel_valid),
    .clear(clear),
    .window_out(window_out),
    .window_valid(window_valid),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [OW-1:0] obs,
                     input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] tap(input logic [OW-1:0] v,
                                        input int k);
    return v[k*DW +: DW];
  endfunction

  task automatic idle();
    @(negedge clk);
    pixel_valid = 1'b0;
    clear = 1'b0;
    @(posedge clk);
    #1;
    chk("gap_valid", OW'(window_valid), OW'(0));
    chk("gap_hold", window_out, last_w);
  endtask

  task automatic send_pix(input int r, input int c, input bit clr);
    logic [OW-1:0] expw;
    bit ev;
    @(negedge clk);
    pixel_in = DW'(r * 8 + c);
    pixel_valid = 1'b1;
    clear = clr;
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    clear = 1'b0;
    ev = !clr && r >= 4 && c >= 4;
    chk("valid", OW'(window_valid), OW'(ev));
    chk("frame_done", OW'(frame_done), OW'(ev && r == H - 1 && c == W - 1));
    if (ev) begin
      expw = '0;
      for (int k = 0; k < 25; k++) begin
        expw[k*DW +: DW] = DW'((r - 4 + k / 5) * 8 + (c - 4 + k % 5));
      end
      chk("window", window_out, expw);
      last_w = expw;
      pulses++;
      if (r == 4 && c == 4) begin
        chk("first_tap0", OW'(tap(window_out, 0)), OW'(0));
        chk("first_tap5", OW'(tap(window_out, 5)), OW'(8));
        chk("first_tap24", OW'(tap(window_out, 24)), OW'(36));
      end
      if (r == H - 1 && c == W - 1) begin
        chk("last_tap0", OW'(tap(window_out, 0)), OW'(27));
        chk("last_tap24", OW'(tap(window_out, 24)), OW'(63));
      end
    end else begin
      chk("hold", window_out, last_w);
    end
  endtask

  task automatic run_frame(input int maxgap, input int first);
    pulses = 0;
    for (int p = first; p < W * H; p++) begin
      if (maxgap > 0) begin
        repeat ($urandom_range(0, maxgap)) idle();
      end
      send_pix(p / W, p % W, 1'b0);
    end
    chk("pulse_count", OW'(pulses), OW'(first == 0 ? 16 : pulses));
  endtask

  initial begin
    reset = 1'b1;
    pixel_in = '0;
    pixel_valid = 1'b0;
    clear = 1'b0;
    last_w = '0;
    #12;
    chk("rst_window", window_out, '0);
    chk("rst_valid", OW'(window_valid), OW'(0));
    chk("rst_done", OW'(frame_done), OW'(0));
    @(negedge clk);
    reset = 1'b0;
    idle();

    run_frame(0, 0);
    run_frame(5, 0);
    run_frame(0, 0);

    for (int p = 0; p < 5 * W + 2; p++) begin
      send_pix(p / W, p % W, 1'b0);
    end
    send_pix(0, 0, 1'b1);
    run_frame(0, 1);
    chk("clear_pulses", OW'(pulses), OW'(16));

    for (int p = 0; p < 4 * W + 6; p++) begin
      send_pix(p / W, p % W, 1'b0);
    end
    chk("pre_rst_valid", OW'(window_valid), OW'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", OW'(window_valid), OW'(0));
    chk("async_window", window_out, '0);
    chk("async_done", OW'(frame_done), OW'(0));
    @(negedge clk);
    reset = 1'b0;
    last_w = '0;
    run_frame(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
